exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of registers, immediates and ALU datapath.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register index width (2**REG_ADDR_WIDTH registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  instruction valid this cycle; when low, no write-back is scheduled.
REQ-006 rs1  input  REG_ADDR_WIDTH  source register 1 index.
REQ-007 rs2  input  REG_ADDR_WIDTH  source register 2 index.
REQ-008 rd  input  REG_ADDR_WIDTH  destination register index.
REQ-009 ImmOp  input  DATA_WIDTH  sign-extended immediate from decode.
REQ-010 RegWrite  input  1  schedule a write-back of the ALU result to rd.
REQ-011 ALUctrl  input  3  ALU operation select.
REQ-012 ALUsrc  input  1  operand B select: 0 = rs2 value, 1 = ImmOp.
REQ-013 EQ  output  1  rs1 value equals rs2 value, combinational, same cycle.
REQ-014 ALUout  output  DATA_WIDTH  combinational ALU result, same cycle.
REQ-015 wb_valid  output  1  registered, write-back pending this cycle.
REQ-016 wb_rd  output  REG_ADDR_WIDTH  registered write-back destination.
REQ-017 wb_data  output  DATA_WIDTH  registered write-back value.
REQ-018 a0  output  DATA_WIDTH  registered mirror of register x10.

Function
REQ-019 Register file SHALL hold 2**REG_ADDR_WIDTH entries; x0 SHALL read 0 at all times, and writes to x0 SHALL be discarded.
REQ-020 Pipeline: ALU result computed in cycle N SHALL be captured into wb_data/wb_rd, with wb_valid = en & RegWrite & (rd != 0), at the edge ending N; it SHALL be written to the register file at the edge ending N+1.
REQ-021 Bypass: in cycle N+1, a read of rs1 or rs2 equal to a valid wb_rd SHALL return wb_data, not the stale register-file entry; this applies to both ALU operands and EQ.
REQ-022 Operand A = rs1 value; operand B = ALUsrc ? ImmOp : rs2 value.
REQ-023 ALUctrl: 000 add; 001 sub (A-B); 010 and; 011 or; 100 slt signed (result 1 or 0); 101 sll by B[4:0]; 110 srl logical by B[4:0]; 111 xor.
REQ-024 Add and sub SHALL wrap modulo 2**DATA_WIDTH; no overflow flag is produced.
REQ-025 EQ SHALL always compare the rs1 and rs2 values and SHALL ignore ALUsrc and ALUctrl.
REQ-026 en low SHALL force wb_valid to 0 at the next edge; EQ and ALUout still reflect the inputs.
REQ-027 Back-to-back writes to the same rd: each cycle's wb register SHALL overwrite the previous one, and the register file receives both writes in order.
REQ-028 a0 SHALL update at the same edge the register file writes x10, with the written value.

Reset
REQ-029 While rst is high at a rising edge, all register-file entries, wb_valid, wb_rd, wb_data and a0 SHALL become 0.
REQ-030 A write-back pending when rst asserts SHALL be discarded, never reaching the register file.
REQ-031 In the first cycle after rst deasserts, all register reads SHALL return 0 and EQ SHALL be 1 for any rs1/rs2.

Verification
REQ-032 Reset, then rs1=0, rs2=0 -> EQ=1, a0=0, wb_valid=0.
REQ-033 addi x10,x0,5 (ALUsrc=1, ImmOp=5, ALUctrl=000, rd=10), then idle -> wb_data=5 one edge later, a0=5 two edges later.
REQ-034 x1=7 set; next cycle add x2,x1,x1 -> ALUout=14 via bypass; following cycle rs1=2 -> reads 14.
REQ-035 rd=0, RegWrite=1, ImmOp=9 -> wb_valid=0; x0 still reads 0.
REQ-036 x3=0xFFFFFFFF, x4=1: add -> 0; slt x3,x4 -> 1; srl x3 by 4 -> 0x0FFFFFFF; EQ(x3,x4)=0.
REQ-037 Write scheduled to x10 with value 3, rst asserted the next cycle -> a0 remains 0 and x10 reads 0 after reset.

Source files
------------

// File: rtl/exec_unit_if.sv
// exec_unit_if -- instruction/result bundle of the execute stage.
//   master : decode side, drives the instruction fields and observes results.
//   slave  : exec_unit side.
//   Inputs : en, rs1, rs2, rd, ImmOp, RegWrite, ALUctrl, ALUsrc
//   Outputs: EQ, ALUout (combinational), wb_valid, wb_rd, wb_data, a0 (registered)
interface exec_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      en;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]     ImmOp;
  logic                      RegWrite;
  logic [2:0]                ALUctrl;
  logic                      ALUsrc;
  logic                      EQ;
  logic [DATA_WIDTH-1:0]     ALUout;
  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic [DATA_WIDTH-1:0]     a0;

  modport master (
    output en, rs1, rs2, rd, ImmOp, RegWrite, ALUctrl, ALUsrc,
    input  EQ, ALUout, wb_valid, wb_rd, wb_data, a0
  );

  modport slave (
    input  en, rs1, rs2, rd, ImmOp, RegWrite, ALUctrl, ALUsrc,
    output EQ, ALUout, wb_valid, wb_rd, wb_data, a0
  );
endinterface

// File: rtl/exec_unit.sv
// exec_unit -- register file + ALU + one-stage write-back register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (register file, wb stage, a0)
//   bus  : exec_unit_if.slave
//     en/rs1/rs2/rd/ImmOp/RegWrite/ALUctrl/ALUsrc : instruction this cycle
//     EQ, ALUout                                  : same-cycle results
//     wb_valid/wb_rd/wb_data                      : result waiting to be written
//     a0                                          : registered copy of x10
// An ALU result is parked in the wb register for one cycle and lands in the
// register file at the following edge; reads in between are bypassed from it.
module exec_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic        clk,
  input  logic        rst,
  exec_unit_if.slave  bus
);
  localparam int DW   = DATA_WIDTH;
  localparam int AW   = REG_ADDR_WIDTH;
  localparam int NREG = 2 ** AW;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam logic [AW-1:0] A0_IDX = AW'(10);

  logic [NREG-1:0][DW-1:0] rf_q;
  logic                    wb_valid_q, wb_valid_d;
  logic [AW-1:0]           wb_rd_q,    wb_rd_d;
  logic [DW-1:0]           wb_data_q,  wb_data_d;
  logic [DW-1:0]           a0_q;

  logic [DW-1:0] rs1_val, rs2_val;
  logic [DW-1:0] opa, opb, alu;
  logic [4:0]    shamt;
  logic          slt;

  // Read ports: x0 is hard zero, then the pending write-back wins over the
  // not-yet-updated register file entry.
  always_comb begin
    rs1_val = rf_q[bus.rs1];
    if (bus.rs1 == '0)
      rs1_val = '0;
    else if (wb_valid_q && (wb_rd_q == bus.rs1))
      rs1_val = wb_data_q;
  end

  always_comb begin
    rs2_val = rf_q[bus.rs2];
    if (bus.rs2 == '0)
      rs2_val = '0;
    else if (wb_valid_q && (wb_rd_q == bus.rs2))
      rs2_val = wb_data_q;
  end

  assign opa   = rs1_val;
  assign opb   = bus.ALUsrc ? bus.ImmOp : rs2_val;
  assign shamt = opb[4:0];
  assign slt   = $signed(opa) < $signed(opb);

  always_comb begin
    alu = '0;
    case (bus.ALUctrl)
      OP_ADD:  alu = opa + opb;
      OP_SUB:  alu = opa - opb;
      OP_AND:  alu = opa & opb;
      OP_OR:   alu = opa | opb;
      OP_SLT:  alu = {{(DW-1){1'b0}}, slt};
      OP_SLL:  alu = opa << shamt;
      OP_SRL:  alu = opa >> shamt;
      OP_XOR:  alu = opa ^ opb;
      default: alu = '0;
    endcase
  end

  // wb_rd/wb_data are captured every cycle; only wb_valid decides whether
  // the register file is touched, so x0 and idle cycles never write.
  assign wb_valid_d = bus.en & bus.RegWrite & (bus.rd != '0);
  assign wb_rd_d    = bus.rd;
  assign wb_data_d  = alu;

  // Reset takes priority over the pending write-back, which is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      a0_q       <= '0;
    end else begin
      if (wb_valid_q) begin
        rf_q[wb_rd_q] <= wb_data_q;
        if (wb_rd_q == A0_IDX)
          a0_q <= wb_data_q;
      end
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.EQ       = (rs1_val == rs2_val);
  assign bus.ALUout   = alu;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.a0       = a0_q;
endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  exec_unit_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  exec_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one instruction; settle combinational outputs before returning.
  task automatic drv(input logic en, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                     input logic [AW-1:0] rd, input logic [DW-1:0] imm, input logic rw,
                     input logic [2:0] ctrl, input logic src);
    bus.en = en; bus.rs1 = rs1; bus.rs2 = rs2; bus.rd = rd;
    bus.ImmOp = imm; bus.RegWrite = rw; bus.ALUctrl = ctrl; bus.ALUsrc = src;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, '0, '0, '0, '0, 1'b0, 3'b000, 1'b0);
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_wb_data",  bus.wb_data, 32'd0);
    chk("rst_a0",       bus.a0, 32'd0);
    rst = 1'b0;

    // first cycle after reset: any pair reads equal zeros
    drv(1'b0, 5'd5, 5'd7, '0, '0, 1'b0, 3'b000, 1'b0);
    chk("post_rst_eq", {31'd0, bus.EQ}, 32'd1);
    drv(1'b0, 5'd0, 5'd0, '0, '0, 1'b0, 3'b000, 1'b0);
    chk("x0_eq", {31'd0, bus.EQ}, 32'd1);

    // addi x10,x0,5
    drv(1'b1, 5'd0, 5'd0, 5'd10, 32'd5, 1'b1, 3'b000, 1'b1);
    chk("addi_aluout", bus.ALUout, 32'd5);
    step();
    idle();
    chk("addi_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    chk("addi_wb_rd",    {27'd0, bus.wb_rd}, 32'd10);
    chk("addi_wb_data",  bus.wb_data, 32'd5);
    chk("addi_a0_early", bus.a0, 32'd0);
    step();
    chk("addi_a0", bus.a0, 32'd5);
    chk("idle_wb_valid", {31'd0, bus.wb_valid}, 32'd0);

    // x1=7, then add x2,x1,x1 through the bypass
    drv(1'b1, 5'd0, 5'd0, 5'd1, 32'd7, 1'b1, 3'b000, 1'b1);
    step();
    drv(1'b1, 5'd1, 5'd1, 5'd2, '0, 1'b1, 3'b000, 1'b0);
    chk("byp_add", bus.ALUout, 32'd14);
    chk("byp_eq", {31'd0, bus.EQ}, 32'd1);
    step();
    drv(1'b0, 5'd2, 5'd0, '0, '0, 1'b0, 3'b000, 1'b0);
    chk("byp_rd_x2", bus.ALUout, 32'd14);
    step();
    chk("rf_rd_x2", bus.ALUout, 32'd14);
    drv(1'b0, 5'd1, 5'd0, '0, '0, 1'b0, 3'b000, 1'b0);
    chk("rf_rd_x1", bus.ALUout, 32'd7);

    // write to x0 is suppressed
    drv(1'b1, 5'd0, 5'd0, 5'd0, 32'd9, 1'b1, 3'b000, 1'b1);
    step();
    idle();
    chk("x0_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    step();
    chk("x0_reads_0", bus.ALUout, 32'd0);

    // en low blocks the write even with RegWrite set
    drv(1'b0, 5'd0, 5'd0, 5'd6, 32'd33, 1'b1, 3'b000, 1'b1);
    chk("en0_aluout", bus.ALUout, 32'd33);
    step();
    chk("en0_wb_valid", {31'd0, bus.wb_valid}, 32'd0);

    // x3=-1, x4=1 and the ALU ops on them
    drv(1'b1, 5'd0, 5'd0, 5'd3, 32'hFFFF_FFFF, 1'b1, 3'b000, 1'b1);
    step();
    drv(1'b1, 5'd0, 5'd0, 5'd4, 32'd1, 1'b1, 3'b000, 1'b1);
    step();
    drv(1'b0, 5'd3, 5'd4, '0, '0, 1'b0, 3'b000, 1'b0);
    chk("add_wrap", bus.ALUout, 32'd0);
    chk("eq_x3_x4", {31'd0, bus.EQ}, 32'd0);
    drv(1'b0, 5'd3, 5'd4, '0, '0, 1'b0, 3'b001, 1'b0);
    chk("sub", bus.ALUout, 32'hFFFF_FFFE);
    drv(1'b0, 5'd3, 5'd4, '0, '0, 1'b0, 3'b010, 1'b0);
    chk("and", bus.ALUout, 32'd1);
    drv(1'b0, 5'd3, 5'd4, '0, '0, 1'b0, 3'b011, 1'b0);
    chk("or", bus.ALUout, 32'hFFFF_FFFF);
    drv(1'b0, 5'd3, 5'd4, '0, '0, 1'b0, 3'b100, 1'b0);
    chk("slt_x3_x4", bus.ALUout, 32'd1);
    drv(1'b0, 5'd4, 5'd3, '0, '0, 1'b0, 3'b100, 1'b0);
    chk("slt_x4_x3", bus.ALUout, 32'd0);
    drv(1'b0, 5'd3, 5'd4, '0, '0, 1'b0, 3'b111, 1'b0);
    chk("xor", bus.ALUout, 32'hFFFF_FFFE);
    drv(1'b0, 5'd3, 5'd0, '0, 32'd4, 1'b0, 3'b110, 1'b1);
    chk("srl4", bus.ALUout, 32'h0FFF_FFFF);
    drv(1'b0, 5'd3, 5'd0, '0, 32'h24, 1'b0, 3'b110, 1'b1);
    chk("srl_shamt_5b", bus.ALUout, 32'h0FFF_FFFF);
    drv(1'b0, 5'd4, 5'd0, '0, 32'd31, 1'b0, 3'b101, 1'b1);
    chk("sll31", bus.ALUout, 32'h8000_0000);
    drv(1'b0, 5'd3, 5'd4, '0, '0, 1'b0, 3'b101, 1'b1);
    chk("eq_ignores_src", {31'd0, bus.EQ}, 32'd0);

    // back-to-back writes to x5
    drv(1'b1, 5'd0, 5'd0, 5'd5, 32'd1, 1'b1, 3'b000, 1'b1);
    step();
    drv(1'b1, 5'd0, 5'd0, 5'd5, 32'd2, 1'b1, 3'b000, 1'b1);
    step();
    drv(1'b0, 5'd5, 5'd0, '0, '0, 1'b0, 3'b000, 1'b0);
    chk("b2b_bypass", bus.ALUout, 32'd2);
    step();
    chk("b2b_rf", bus.ALUout, 32'd2);

    // pending write to x10 killed by reset
    drv(1'b1, 5'd0, 5'd0, 5'd10, 32'd3, 1'b1, 3'b000, 1'b1);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_kill_a0", bus.a0, 32'd0);
    chk("rst_kill_valid", {31'd0, bus.wb_valid}, 32'd0);
    drv(1'b0, 5'd10, 5'd0, '0, '0, 1'b0, 3'b000, 1'b0);
    chk("rst_x10_reads_0", bus.ALUout, 32'd0);
    drv(1'b0, 5'd1, 5'd2, '0, '0, 1'b0, 3'b000, 1'b0);
    chk("rst_eq_x1_x2", {31'd0, bus.EQ}, 32'd1);
    step();
    chk("rst_a0_stays", bus.a0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
